// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared constants for the button conditioner
package btn_pkg;

  localparam int N_BTN                   = 3;
  localparam int BTN_CLEAR               = 0;
  localparam int BTN_START               = 1;
  localparam int BTN_STOP                = 2;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  // Counter width for a window of d cycles; never narrower than one bit.
  function automatic int cnt_width(input int d);
    return (d < 3) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - raw buttons in, debounced level and pulses out
// btn_release exists only when BTN_RELEASE_PULSE_EN is defined.
interface button_conditioner_if #(
  parameter int N_BTN = btn_pkg::N_BTN
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
`ifdef BTN_RELEASE_PULSE_EN
  logic [N_BTN-1:0] btn_release;
`endif

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press
`ifdef BTN_RELEASE_PULSE_EN
    ,
    input  btn_release
`endif
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output btn_release
`endif
  );

endinterface

// File: rtl/button_conditioner_debounce_cell.sv
// rtl/button_conditioner_debounce_cell.sv - one button: synchronizer, window counter, edge pulses
// release_o is built only when BTN_RELEASE_PULSE_EN is defined.
module debounce_cell
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
`ifdef BTN_RELEASE_PULSE_EN
  ,
  output logic release_o
`endif
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
`ifdef BTN_RELEASE_PULSE_EN
  logic          release_q, release_d;
`endif

  // Any agreement with the stable state drops the count, so a bounce restarts the window.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = stable_d & ~stable_q;
`ifdef BTN_RELEASE_PULSE_EN
    release_d = ~stable_d & stable_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
      release_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
`ifdef BTN_RELEASE_PULSE_EN
      release_q <= release_d;
`endif
    end
  end

  assign level_o = stable_q;
  assign press_o = press_q;
`ifdef BTN_RELEASE_PULSE_EN
  assign release_o = release_q;
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounces N_BTN buttons feeding the reaction-timer clear/start/stop
// Optional btn_release pulses with BTN_RELEASE_PULSE_EN defined.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES_DEFAULT,
  parameter int N_BTN           = btn_pkg::N_BTN
) (
  input logic                 clk,
  input logic                 rst,
  button_conditioner_if.slave btn
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
`ifdef BTN_RELEASE_PULSE_EN
  logic [N_BTN-1:0] release_p;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (btn.btn_raw[i]),
      .level_o  (level[i]),
      .press_o  (press[i])
`ifdef BTN_RELEASE_PULSE_EN
      ,
      .release_o(release_p[i])
`endif
    );
  end

  assign btn.btn_level = level;
  assign btn.btn_press = press;
`ifdef BTN_RELEASE_PULSE_EN
  assign btn.btn_release = release_p;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed checks against a window-based reference model
// Release checks are active when BTN_RELEASE_PULSE_EN is defined.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  button_conditioner_if #(.N_BTN(N)) bif ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .N_BTN          (N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(bif)
  );

  int total = 0;
  int bad   = 0;

  logic         rst_h[$];
  logic [N-1:0] raw_h[$];
  logic [N-1:0] m_level = '0;
  logic [N-1:0] m_press = '0;
  logic [N-1:0] m_rel   = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Value the debounce logic sees at edge m: raw sampled two edges earlier,
  // forced to 0 if either synchronizer stage was reset since.
  function automatic logic [N-1:0] seen(input int m);
    if (m < 2) return '0;
    if (rst_h[m-1] || rst_h[m-2]) return '0;
    return raw_h[m-2];
  endfunction

  // A button flips when the last D edges were all out of reset and all saw
  // the opposite of its debounced level.
  task automatic step();
    int j;
    logic ok;
    logic [N-1:0] s;
    @(posedge clk);
    rst_h.push_back(rst);
    raw_h.push_back(bif.btn_raw);
    j = rst_h.size() - 1;
    m_press = '0;
    m_rel   = '0;
    if (rst) begin
      m_level = '0;
    end else begin
      for (int b = 0; b < N; b++) begin
        ok = (j >= D - 1);
        for (int k = j - D + 1; k <= j; k++) begin
          if (k < 0) begin
            ok = 1'b0;
          end else begin
            s = seen(k);
            if (rst_h[k] || s[b] == m_level[b]) ok = 1'b0;
          end
        end
        if (ok) begin
          m_level[b] = ~m_level[b];
          if (m_level[b]) m_press[b] = 1'b1;
          else            m_rel[b]   = 1'b1;
        end
      end
    end
    #1;
    check_eq("level", 32'(bif.btn_level), 32'(m_level));
    check_eq("press", 32'(bif.btn_press), 32'(m_press));
`ifdef BTN_RELEASE_PULSE_EN
    check_eq("release", 32'(bif.btn_release), 32'(m_rel));
`endif
  endtask

  task automatic idle(input int n);
    bif.btn_raw = '0;
    rst = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Edges until btn_press[b] first pulses (1 = the first edge after the stimulus).
  task automatic press_latency(input int b, input int budget, output int lat, output int cnt);
    lat = 0;
    cnt = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (bif.btn_press[b]) begin
        cnt++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  int lat, cnt, all_cnt;
  int left[N];

  initial begin
    rst = 1'b1;
    bif.btn_raw = '0;
    for (int i = 0; i < 4; i++) step();
    check_eq("reset_level", 32'(bif.btn_level), 32'd0);
    bif.btn_raw = 3'b111;
    for (int i = 0; i < 3; i++) step();
    idle(D + 4);

    // clean press on start
    bif.btn_raw = 3'b010;
    press_latency(1, 20, lat, cnt);
    check_eq("clean_lat", 32'(lat), 32'(D + 2));
    check_eq("clean_cnt", 32'(cnt), 32'd1);
    idle(D + 6);

    // bounce on clear: high 2, low 1, then steady
    cnt = 0;
    bif.btn_raw = 3'b001; step(); cnt += int'(bif.btn_press[0]);
    step(); cnt += int'(bif.btn_press[0]);
    bif.btn_raw = 3'b000; step(); cnt += int'(bif.btn_press[0]);
    bif.btn_raw = 3'b001;
    press_latency(0, 20, lat, all_cnt);
    check_eq("bounce_lat", 32'(lat), 32'(D + 2));
    check_eq("bounce_cnt", 32'(cnt + all_cnt), 32'd1);
    idle(D + 6);

    // long hold on stop
    bif.btn_raw = 3'b100;
    press_latency(2, 100, lat, cnt);
    check_eq("hold_cnt", 32'(cnt), 32'd1);
    check_eq("hold_level", 32'(bif.btn_level[2]), 32'd1);
    idle(D + 6);

    // simultaneous presses
    bif.btn_raw = 3'b111;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bif.btn_press == 3'b111) cnt++;
    end
    check_eq("simul_cnt", 32'(cnt), 32'd1);
    idle(D + 6);

    // reset three cycles into the window, button still held
    bif.btn_raw = 3'b010;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    press_latency(1, 20, lat, cnt);
    check_eq("rst_lat", 32'(lat), 32'(D + 2));
    check_eq("rst_cnt", 32'(cnt), 32'd1);
    idle(D + 6);

`ifdef BTN_RELEASE_PULSE_EN
    bif.btn_raw = 3'b001;
    for (int i = 0; i < D + 2 + 20; i++) step();
    bif.btn_raw = 3'b000;
    lat = 0;
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (bif.btn_release[0]) begin
        cnt++;
        if (lat == 0) lat = i;
      end
    end
    check_eq("rel_lat", 32'(lat), 32'(D + 2));
    check_eq("rel_cnt", 32'(cnt), 32'd1);
    idle(D + 6);
`endif

    // randomized bouncing with occasional resets
    for (int b = 0; b < N; b++) left[b] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        left[b]--;
        if (left[b] == 0) begin
          bif.btn_raw[b] = ~bif.btn_raw[b];
          left[b] = int'($urandom_range(1, 2 * D + 2));
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    idle(D + 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
